// File: rtl/ir_fetch_seq_pkg.sv
// Shared types and constants for the byte-wide instruction fetch sequencer.
package ir_fetch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [1:0] FUNSEL_HOLD = 2'b00;
    localparam logic [1:0] FUNSEL_LOAD = 2'b01;

    localparam logic L_H_LOW  = 1'b0;
    localparam logic L_H_HIGH = 1'b1;

    // States in which a memory read is outstanding.
    function automatic logic is_fetch(input state_t s);
        return (s == FETCH_LO) || (s == FETCH_HI);
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Per-byte memory wait counter; flags the cycle in which the wait budget runs out.
module fetch_timeout_ctr
    import ir_fetch_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expire on the wait cycle that would bring the count to TIMEOUT_CYC.
    assign expire = inc && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ir_fetch_seq.sv
// Fetches a 16-bit instruction as two bytes (PC, PC+1) into the IR half-load port.
// Optional per-byte memory timeout is enabled with `define FETCH_TIMEOUT_EN.
module ir_fetch_seq
    import ir_fetch_seq_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    input  logic              mem_valid,
    output logic [7:0]        ir_half,
    output logic [1:0]        ir_funsel,
    output logic              ir_e,
    output logic              ir_l_h,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic [7:0]        ir_half_q, ir_half_d;
    logic [1:0]        ir_funsel_q, ir_funsel_d;
    logic              ir_e_q, ir_e_d;
    logic              ir_l_h_q, ir_l_h_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

`ifdef FETCH_TIMEOUT_EN
    logic [ADDR_W-1:0] base_q, base_d;
    logic              wait_clr;
    logic              wait_inc;
    logic              wait_expire;

    // Counter restarts whenever the FSM changes state, i.e. on entry to each byte.
    assign wait_clr = (state_d != state_q);
    assign wait_inc = is_fetch(state_q) && !mem_valid;

    fetch_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (wait_clr),
        .inc    (wait_inc),
        .expire (wait_expire)
    );
`else
    // TIMEOUT_CYC has no effect when the timeout feature is compiled out.
    if (TIMEOUT_CYC < 1) begin : g_timeout_cfg_unused
    end
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_half_d   = ir_half_q;
        ir_l_h_d    = ir_l_h_q;
        ir_e_d      = 1'b0;
        ir_funsel_d = FUNSEL_HOLD;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        base_d      = base_q;
`endif

        case (state_q)
            IDLE: begin
                if (pc_load) begin
                    pc_d = pc_in;
                end
                if (start) begin
                    state_d = FETCH_LO;
`ifdef FETCH_TIMEOUT_EN
                    base_d  = pc_load ? pc_in : pc_q;
`endif
                end
            end
            FETCH_LO, FETCH_HI: begin
                if (mem_valid) begin
                    ir_half_d   = mem_data;
                    ir_l_h_d    = (state_q == FETCH_HI) ? L_H_HIGH : L_H_LOW;
                    ir_e_d      = 1'b1;
                    ir_funsel_d = FUNSEL_LOAD;
                    pc_d        = pc_q + ADDR_W'(1);
                    if (state_q == FETCH_HI) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH_HI;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_expire) begin
                    // Abandon the fetch; a low byte already in the IR stays there.
                    state_d = IDLE;
                    pc_d    = base_q;
                    err_d   = 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Memory port and busy are registered views of the next state/PC.
        mem_rd_d   = is_fetch(state_d);
        mem_addr_d = pc_d;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            ir_half_q   <= 8'h00;
            ir_funsel_q <= FUNSEL_HOLD;
            ir_e_q      <= 1'b0;
            ir_l_h_q    <= L_H_LOW;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            base_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            ir_half_q   <= ir_half_d;
            ir_funsel_q <= ir_funsel_d;
            ir_e_q      <= ir_e_d;
            ir_l_h_q    <= ir_l_h_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef FETCH_TIMEOUT_EN
            base_q      <= base_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign ir_half   = ir_half_q;
    assign ir_funsel = ir_funsel_q;
    assign ir_e      = ir_e_q;
    assign ir_l_h    = ir_l_h_q;
    assign pc_out    = pc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ir_fetch_seq.sv
// Directed bench for ir_fetch_seq: byte memory model, IR model, per-scenario tasks.
module tb_ir_fetch_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic [7:0]  mem_data = 8'h00;
    logic        mem_valid = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  ir_half;
    logic [1:0]  ir_funsel;
    logic        ir_e;
    logic        ir_l_h;
    logic [15:0] pc_out;
    logic        busy;
    logic        done;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;

    // Memory responder state
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    bit          rd_prev = 1'b0;
    bit          mem_enable = 1'b1;
    bit          stall_en = 1'b0;
    logic [15:0] stall_addr = 16'h0000;

    // IR model built from observed strobes
    logic [15:0] ir_model = 16'h0000;
    int          ir_e_count = 0;

    ir_fetch_seq #(
        .ADDR_W      (16),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_valid (mem_valid),
        .ir_half   (ir_half),
        .ir_funsel (ir_funsel),
        .ir_e      (ir_e),
        .ir_l_h    (ir_l_h),
        .pc_out    (pc_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h0040: return 8'hCD;
            16'h0041: return 8'hAB;
            16'hFFFF: return 8'h5A;
            16'h0000: return 8'hA5;
            default:  return a[7:0] ^ 8'h3C;
        endcase
    endfunction

    // Advance to the next falling edge, then drive memory and record IR strobes.
    task automatic tick();
        @(negedge clk);
        if (mem_rd === 1'b1 && rd_prev && !mem_valid) wait_cnt++;
        else wait_cnt = 0;
        rd_prev   = (mem_rd === 1'b1);
        mem_valid = (mem_rd === 1'b1) && mem_enable &&
                    !(stall_en && (mem_addr == stall_addr)) && (wait_cnt >= wait_cfg);
        mem_data  = mem_byte(mem_addr);
        if (ir_e === 1'b1 && ir_funsel === 2'b01) begin
            ir_e_count++;
            if (ir_l_h) ir_model[15:8] = ir_half;
            else        ir_model[7:0]  = ir_half;
        end
    endtask

    task automatic clear_models();
        ir_model   = 16'h0000;
        ir_e_count = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({busy, done, err, mem_rd, ir_e, ir_l_h, ir_funsel} !== 8'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy, done, err, mem_rd, ir_e, ir_l_h, ir_funsel});
        end
        tests_run++;
        if ({pc_out, mem_addr, ir_half} !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_data: pc=%h addr=%h half=%h want zeros", pc_out, mem_addr, ir_half);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait();
        clear_models();
        wait_cfg = 0;
        pc_load = 1'b1; pc_in = 16'h0040; start = 1'b1;
        tick();                                   // FETCH_LO
        pc_load = 1'b0; start = 1'b0;
        tests_run++;
        if ({busy, mem_rd, ir_e, mem_addr} !== {3'b110, 16'h0040}) begin
            tests_failed++;
            $display("FAIL zw_lo: busy=%b rd=%b ir_e=%b addr=%h want 1 1 0 0040", busy, mem_rd, ir_e, mem_addr);
        end
        tick();                                   // FETCH_HI
        tests_run++;
        if ({mem_rd, ir_e, ir_l_h, ir_funsel, ir_half, mem_addr} !== {5'b11001, 8'hCD, 16'h0041}) begin
            tests_failed++;
            $display("FAIL zw_hi: rd=%b e=%b lh=%b fs=%b half=%h addr=%h want 1 1 0 01 CD 0041",
                     mem_rd, ir_e, ir_l_h, ir_funsel, ir_half, mem_addr);
        end
        tick();                                   // DONE
        tests_run++;
        if ({done, mem_rd, ir_e, ir_l_h, ir_funsel, ir_half, pc_out} !== {6'b101101, 8'hAB, 16'h0042}) begin
            tests_failed++;
            $display("FAIL zw_done: done=%b rd=%b e=%b lh=%b fs=%b half=%h pc=%h want 1 0 1 1 01 AB 0042",
                     done, mem_rd, ir_e, ir_l_h, ir_funsel, ir_half, pc_out);
        end
        tick();                                   // IDLE
        tests_run++;
        if ({busy, done, ir_e, ir_funsel, ir_l_h, ir_half} !== {6'b000001, 8'hAB}) begin
            tests_failed++;
            $display("FAIL zw_idle: busy=%b done=%b e=%b fs=%b lh=%b half=%h want 0 0 0 00 1 AB",
                     busy, done, ir_e, ir_funsel, ir_l_h, ir_half);
        end
        tests_run++;
        if (ir_model !== 16'hABCD || ir_e_count != 2) begin
            tests_failed++;
            $display("FAIL zw_ir: ir=%h pulses=%0d want ABCD 2", ir_model, ir_e_count);
        end
    endtask

    task automatic test_wait_states();
        int done_cyc;
        logic        exp_rd;
        logic [15:0] exp_addr;
        clear_models();
        done_cyc = 0;
        wait_cfg = 3;
        pc_load = 1'b1; pc_in = 16'h0100; start = 1'b1;
        for (int cyc = 2; cyc <= 12; cyc++) begin
            tick();
            pc_load = 1'b0; start = 1'b0;
            exp_rd   = (cyc <= 9);
            exp_addr = (cyc <= 5) ? 16'h0100 : ((cyc <= 9) ? 16'h0101 : 16'h0102);
            tests_run++;
            if ({mem_rd, mem_addr} !== {exp_rd, exp_addr}) begin
                tests_failed++;
                $display("FAIL ws_port c%0d: rd=%b addr=%h want %b %h", cyc, mem_rd, mem_addr, exp_rd, exp_addr);
            end
            if (done === 1'b1) done_cyc = cyc;
        end
        tests_run++;
        if (done_cyc != 10 || ir_e_count != 2 || pc_out !== 16'h0102 || ir_model !== 16'h3D3C) begin
            tests_failed++;
            $display("FAIL ws_result: done_cyc=%0d pulses=%0d pc=%h ir=%h want 10 2 0102 3D3C",
                     done_cyc, ir_e_count, pc_out, ir_model);
        end
        wait_cfg = 0;
    endtask

    task automatic test_wrap();
        clear_models();
        pc_load = 1'b1; pc_in = 16'hFFFF;
        tick();
        pc_load = 1'b0;
        tests_run++;
        if ({busy, pc_out} !== {1'b0, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL wrap_load: busy=%b pc=%h want 0 FFFF", busy, pc_out);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({mem_rd, mem_addr} !== {1'b1, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL wrap_lo: rd=%b addr=%h want 1 FFFF", mem_rd, mem_addr);
        end
        tick();
        tests_run++;
        if ({mem_rd, mem_addr, ir_e, ir_l_h, ir_half} !== {1'b1, 16'h0000, 2'b10, 8'h5A}) begin
            tests_failed++;
            $display("FAIL wrap_hi: rd=%b addr=%h e=%b lh=%b half=%h want 1 0000 1 0 5A",
                     mem_rd, mem_addr, ir_e, ir_l_h, ir_half);
        end
        tick();
        tests_run++;
        if ({done, pc_out} !== {1'b1, 16'h0001} || ir_model !== 16'hA55A) begin
            tests_failed++;
            $display("FAIL wrap_done: done=%b pc=%h ir=%h want 1 0001 A55A", done, pc_out, ir_model);
        end
        tick();
    endtask

    task automatic test_ignored_inputs();
        clear_models();
        start = 1'b1;                             // PC is 0x0001 from the wrap test
        tick();                                   // FETCH_LO
        start = 1'b0;
        tick();                                   // FETCH_HI
        start = 1'b1; pc_load = 1'b1; pc_in = 16'h7777;
        tick();                                   // DONE
        tests_run++;
        if ({done, busy} !== 2'b11) begin
            tests_failed++;
            $display("FAIL ign_done: done=%b busy=%b want 1 1", done, busy);
        end
        tick();                                   // IDLE
        start = 1'b0; pc_load = 1'b0;
        tests_run++;
        if ({busy, done, mem_rd, pc_out} !== {3'b000, 16'h0003}) begin
            tests_failed++;
            $display("FAIL ign_idle: busy=%b done=%b rd=%b pc=%h want 0 0 0 0003", busy, done, mem_rd, pc_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({busy, mem_rd, done, pc_out} !== {3'b000, 16'h0003}) begin
                tests_failed++;
                $display("FAIL ign_quiet%0d: busy=%b rd=%b done=%b pc=%h want 0 0 0 0003",
                         i, busy, mem_rd, done, pc_out);
            end
        end
        tests_run++;
        if (ir_e_count != 2 || ir_model !== 16'h3E3D) begin
            tests_failed++;
            $display("FAIL ign_ir: pulses=%0d ir=%h want 2 3E3D", ir_e_count, ir_model);
        end
    endtask

    task automatic test_reset_mid_fetch();
        clear_models();
        stall_en = 1'b1; stall_addr = 16'h0201;
        pc_load = 1'b1; pc_in = 16'h0200; start = 1'b1;
        tick();                                   // FETCH_LO
        pc_load = 1'b0; start = 1'b0;
        tick();                                   // FETCH_HI, stalled
        tests_run++;
        if ({mem_rd, mem_addr, ir_e, ir_l_h} !== {1'b1, 16'h0201, 2'b10}) begin
            tests_failed++;
            $display("FAIL rmf_hi: rd=%b addr=%h e=%b lh=%b want 1 0201 1 0", mem_rd, mem_addr, ir_e, ir_l_h);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({busy, mem_rd, ir_e, done, ir_funsel, pc_out, mem_addr} !== {6'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL rmf_reset: busy=%b rd=%b e=%b done=%b fs=%b pc=%h addr=%h want all 0",
                     busy, mem_rd, ir_e, done, ir_funsel, pc_out, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({busy, mem_rd, ir_e, done} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL rmf_after%0d: busy=%b rd=%b e=%b done=%b want 0", i, busy, mem_rd, ir_e, done);
            end
        end
        tests_run++;
        if (ir_e_count != 1) begin
            tests_failed++;
            $display("FAIL rmf_strobes: pulses=%0d want 1", ir_e_count);
        end
        stall_en = 1'b0;
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        logic exp_err;
        logic exp_busy;
        // Low-byte timeout: never answered.
        clear_models();
        mem_enable = 1'b0;
        pc_load = 1'b1; pc_in = 16'h0300; start = 1'b1;
        for (int cyc = 2; cyc <= 19; cyc++) begin
            tick();
            pc_load = 1'b0; start = 1'b0;
            exp_err  = (cyc == 17);
            exp_busy = (cyc <= 16);
            tests_run++;
            if ({err, busy, done} !== {exp_err, exp_busy, 1'b0}) begin
                tests_failed++;
                $display("FAIL to_lo c%0d: err=%b busy=%b done=%b want %b %b 0", cyc, err, busy, done, exp_err, exp_busy);
            end
        end
        tests_run++;
        if (pc_out !== 16'h0300 || ir_e_count != 0) begin
            tests_failed++;
            $display("FAIL to_lo_end: pc=%h pulses=%0d want 0300 0", pc_out, ir_e_count);
        end
        mem_enable = 1'b1;
        // High-byte timeout: low byte lands, high byte never answered.
        clear_models();
        stall_en = 1'b1; stall_addr = 16'h0401;
        pc_load = 1'b1; pc_in = 16'h0400; start = 1'b1;
        for (int cyc = 2; cyc <= 20; cyc++) begin
            tick();
            pc_load = 1'b0; start = 1'b0;
            exp_err  = (cyc == 18);
            exp_busy = (cyc <= 17);
            tests_run++;
            if ({err, busy, done} !== {exp_err, exp_busy, 1'b0}) begin
                tests_failed++;
                $display("FAIL to_hi c%0d: err=%b busy=%b done=%b want %b %b 0", cyc, err, busy, done, exp_err, exp_busy);
            end
        end
        tests_run++;
        if (pc_out !== 16'h0400 || ir_e_count != 1 || ir_model[7:0] !== 8'h3C || ir_l_h !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_hi_end: pc=%h pulses=%0d ir_lo=%h lh=%b want 0400 1 3C 0",
                     pc_out, ir_e_count, ir_model[7:0], ir_l_h);
        end
        stall_en = 1'b0;
    endtask
`else
    task automatic test_timeout();
        // Without the timeout feature a silent memory stalls the fetch indefinitely.
        mem_enable = 1'b0;
        pc_load = 1'b1; pc_in = 16'h0500; start = 1'b1;
        for (int cyc = 2; cyc <= 31; cyc++) begin
            tick();
            pc_load = 1'b0; start = 1'b0;
            tests_run++;
            if ({err, busy, mem_rd, done, mem_addr} !== {4'b0110, 16'h0500}) begin
                tests_failed++;
                $display("FAIL stall c%0d: err=%b busy=%b rd=%b done=%b addr=%h want 0 1 1 0 0500",
                         cyc, err, busy, mem_rd, done, mem_addr);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_enable = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_wrap();
        test_ignored_inputs();
        test_reset_mid_fetch();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ir_fetch_seq.md
Name: ir_fetch_seq

Overview:
Byte-wide instruction fetch sequencer that drives the half-word load port of the 16-bit instruction register. On a start request it reads two consecutive bytes from byte-wide memory: low byte at PC, high byte at PC+1. It presents each byte to the IR with the correct low/high select and load strobe, then advances the PC. It sits between the program counter/memory and the IR in the datapath.

Parameters:
ADDR_W, 16, program counter and memory address width in bits
TIMEOUT_CYC, 15, maximum wait cycles for mem_valid per byte; used only when FETCH_TIMEOUT_EN is defined

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request one 16-bit instruction fetch; sampled only in IDLE
pc_load  input  1  load PC from pc_in; honoured only in IDLE
pc_in  input  ADDR_W  PC load value
mem_addr  output  ADDR_W  byte address presented to memory
mem_rd  output  1  memory read request
mem_data  input  8  read data; valid when mem_valid=1
mem_valid  input  1  read-data-valid handshake from memory
ir_half  output  8  byte to the IR half-load input
ir_funsel  output  2  IR function select; 2'b01 = load
ir_e  output  1  IR enable, one-cycle pulse per byte
ir_l_h  output  1  IR half select; 0 = bits [7:0], 1 = bits [15:8]
pc_out  output  ADDR_W  current PC
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when both halves have been loaded
err  output  1  timeout pulse; tied 0 without FETCH_TIMEOUT_EN

Behaviour:
- Reset values: state=IDLE, pc=0, mem_rd=0, mem_addr=0, ir_half=0, ir_funsel=2'b00, ir_e=0, ir_l_h=0, busy=0, done=0, err=0.
- Reset mid-fetch aborts immediately. No IR strobe is issued in the cycle after reset.
- States: IDLE, FETCH_LO, FETCH_HI, DONE.
- IDLE:
  - pc_load=1 sets pc<=pc_in.
  - start=1 goes to FETCH_LO.
  - If pc_load and start are high in the same cycle, the fetch uses pc_in, and mem_addr in FETCH_LO equals pc_in.
  - start and pc_load are ignored in all other states.
- FETCH_LO:
  - mem_rd=1, mem_addr=pc.
  - On mem_valid=1, register ir_half<=mem_data, ir_l_h<=0, ir_funsel<=2'b01, ir_e<=1 for exactly the next cycle.
  - Same edge: pc<=pc+1, go to FETCH_HI.
  - mem_valid=0 holds the state, mem_rd and mem_addr stable.
- FETCH_HI:
  - Same as FETCH_LO with ir_l_h<=1.
  - On mem_valid=1: pc<=pc+1, go to DONE.
- DONE: done=1 for one cycle, then IDLE. A start sampled in this cycle is ignored.
- Strobe rules:
  - ir_e is high exactly one cycle per byte; ir_funsel=2'b01 only while ir_e=1, otherwise 2'b00.
  - ir_half and ir_l_h hold their last values when ir_e=0.
- Latency: with zero-wait memory (mem_valid high the same cycle as mem_rd), start to done is 4 cycles (IDLE→LO→HI→DONE).
- mem_valid while mem_rd=0 is ignored.
- PC arithmetic is modulo 2^ADDR_W: pc=all-ones wraps to 0, so the high byte is fetched from address 0.

Optional Feature:
FETCH_TIMEOUT_EN:
- When defined, a wait counter clears on entering FETCH_LO or FETCH_HI and increments every cycle in which mem_valid=0.
- On reaching TIMEOUT_CYC: err pulses 1 cycle, state goes to IDLE, and pc is restored to the fetch start address.
- If the low byte was already loaded, no further IR strobe is issued; the IR low half keeps the new byte.
- When undefined: no counter, err tied 0, and waits are unbounded.

Decomposition:
- Shared package holds:
  - state enum {IDLE, FETCH_LO, FETCH_HI, DONE};
  - IR funsel constants FUNSEL_HOLD=2'b00 and FUNSEL_LOAD=2'b01;
  - L_H_LOW=0 and L_H_HIGH=1.
- One natural sub-module, fetch_timeout_ctr: the wait counter, instantiated only under FETCH_TIMEOUT_EN.
- FSM, PC and output registers stay in ir_fetch_seq.

Test Plan:
- Zero-wait: pc_load pc_in=16'h0040 with start in the same cycle; memory holds 8'hCD at 0x40 and 8'hAB at 0x41.
  Required: mem_addr 0x40 then 0x41; ir_e pulses with l_h=0/8'hCD then l_h=1/8'hAB; done at cycle 4; pc_out=0x42; IR reads 16'hABCD.
- Wait states: memory delays mem_valid 3 cycles on each byte.
  Required: mem_rd and mem_addr stable while waiting; exactly two ir_e pulses; done at cycle 10; pc advanced by 2.
- Wrap: pc=16'hFFFF, start.
  Required: addresses 0xFFFF then 0x0000; pc_out=16'h0001 after done.
- Ignored inputs: start and pc_load pulsed during FETCH_HI and during DONE.
  Required: no second fetch; pc unchanged by pc_in; busy falls after the single done.
- Reset mid-fetch: rst asserted in FETCH_HI before mem_valid.
  Required: next cycle state IDLE, pc=0, mem_rd=0, ir_e=0, done=0; no IR strobe follows.
- FETCH_TIMEOUT_EN: mem_valid never asserted, TIMEOUT_CYC=15.
  Required: err pulses after 15 wait cycles; pc equals the start address; busy=0; no done.
